// File: rtl/mx_apb_splitter.sv
`default_nettype none
// ============================================================================
// Module   : mx_apb_splitter
// Brief    : One APB master to NUM_SLV APB slaves. Decodes a fixed address
//            window, replays the transfer to the selected slave and aborts a
//            stuck slave access after TIMEOUT ACCESS cycles.
// Revision : 1.0  initial release
// ============================================================================
module mx_apb_splitter #(
   parameter int          NUM_SLV   = 4,
   parameter int          SLV_AW    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          TIMEOUT   = 15
) (
   input  logic                  PClkxCI,
   input  logic                  PResetxARBI,
   input  logic                  PEnClkxSI,
   output logic                  PEnClkxSO,
   // master side
   input  logic                  PSelxSI,
   input  logic                  PEnablexSI,
   input  logic                  PWritexSI,
   input  logic [31:2]           PAddrxDI,
   input  logic [31:0]           PWDataxDI,
   output logic                  PReadyxSO,
   output logic [31:0]           PRDataxDO,
   output logic                  PSlverrxSO,
   // slave side
   output logic [NUM_SLV-1:0]    PSelxSO,
   output logic                  PEnablexSO,
   output logic                  PWritexSO,
   output logic [31:2]           PAddrxDO,
   output logic [31:0]           PWDataxDO,
   input  logic [NUM_SLV-1:0]    PReadyxSI,
   input  logic [NUM_SLV-1:0]    PSlverrxSI,
   input  logic [NUM_SLV*32-1:0] PRDataxDI,
   output logic                  TimeoutxSO
);

   localparam int IDXW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int TOPB = SLV_AW + IDXW;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [31:2]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              write_q, write_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              tout_q, tout_d;

   logic [IDXW-1:0]   w_idx;
   logic              w_hit;
   logic              w_slv_rdy;
   logic              w_slv_err;
   logic [31:0]       w_slv_rdata;

   // Decode of the incoming master address: window match plus slave index range
   assign w_idx = PAddrxDI[TOPB-1:SLV_AW];
   assign w_hit = (PAddrxDI[31:TOPB] == BASE_ADDR[31:TOPB]) &&
                  (32'(w_idx) < 32'(NUM_SLV));

   // Response mux of the currently addressed slave
   always_comb begin
      w_slv_rdy   = 1'b0;
      w_slv_err   = 1'b0;
      w_slv_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx_q == IDXW'(i)) begin
            w_slv_rdy   = PReadyxSI[i];
            w_slv_err   = PSlverrxSI[i];
            w_slv_rdata = PRDataxDI[32*i +: 32];
         end
      end
   end

   // Transfer sequencer next-state logic; registers hold unless a branch overrides
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      tout_d  = tout_q;
      case (state_q)
         S_IDLE: begin
            // Only a master SETUP phase starts a transfer; a held ACCESS phase
            // left over from the previous transfer must not retrigger.
            if (PSelxSI && !PEnablexSI) begin
               addr_d  = PAddrxDI;
               wdata_d = PWDataxDI;
               write_d = PWritexSI;
               idx_d   = w_idx;
               rdata_d = '0;
               tout_d  = 1'b0;
               cnt_d   = '0;
               if (w_hit) begin
                  state_d = S_SETUP;
                  err_d   = 1'b0;
               end else begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
            cnt_d   = '0;
         end
         S_ACCESS: begin
            // Ready takes priority over an expiring timeout in the same cycle
            if (w_slv_rdy) begin
               state_d = S_DONE;
               rdata_d = write_q ? 32'h0 : w_slv_rdata;
               err_d   = w_slv_err;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d = S_DONE;
               rdata_d = '0;
               err_d   = 1'b1;
               tout_d  = 1'b1;
               cnt_d   = cnt_q + 8'd1;
            end else begin
               cnt_d   = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, advanced only on enabled clock cycles
   always_ff @(posedge PClkxCI or negedge PResetxARBI) begin
      if (!PResetxARBI) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tout_q  <= 1'b0;
      end else if (PEnClkxSI) begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         tout_q  <= tout_d;
      end
   end

   // One-hot slave select, active only while the slave transfer is in flight
   always_comb begin
      PSelxSO = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if ((state_q == S_SETUP || state_q == S_ACCESS) && idx_q == IDXW'(i)) begin
            PSelxSO[i] = 1'b1;
         end
      end
   end

   assign PEnClkxSO  = PEnClkxSI;
   assign PEnablexSO = (state_q == S_ACCESS);
   assign PWritexSO  = write_q;
   assign PAddrxDO   = addr_q;
   assign PWDataxDO  = wdata_q;

   // Master response is forced to zero outside DONE
   assign PReadyxSO  = (state_q == S_DONE);
   assign PRDataxDO  = PReadyxSO ? rdata_q : 32'h0;
   assign PSlverrxSO = PReadyxSO & err_q;
   assign TimeoutxSO = PReadyxSO & tout_q;

endmodule
`default_nettype wire

// File: tb/tb_mx_apb_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mx_apb_splitter
// Brief    : Self-checking bench for mx_apb_splitter with a simple slave model
//            and an expected-response queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_mx_apb_splitter;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          en_base = 1'b1;
   logic          en_tgl = 1'b0;
   logic          tgl = 1'b0;
   wire           en = tgl ? en_tgl : en_base;

   logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:2]   paddr = '0;
   logic [31:0]   pwdata = '0;

   logic          o_enclk, o_ready, o_slverr, o_pen, o_pwrite, o_tout;
   logic [31:0]   o_rdata, o_wdata;
   logic [3:0]    o_sel;
   logic [31:2]   o_addr;

   logic [3:0]    s_rdy, s_err;
   logic [127:0]  s_rdata;

   // slave model controls
   logic [7:0]    slv_wait = 8'd0;
   logic          never_rdy = 1'b0;
   logic [3:0]    err_mask = 4'h0;
   logic [31:0]   rd_val [4];
   logic [7:0]    acc_cnt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          tpulses;
      logic [3:0]  sel;
      int          lat;
      logic [31:2] addr;
      logic [31:0] wdata;
      logic        write;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(negedge clk) en_tgl <= ~en_tgl;

   mx_apb_splitter #(.NUM_SLV(4), .SLV_AW(8), .BASE_ADDR(32'h0), .TIMEOUT(15)) dut (
      .PClkxCI     (clk),
      .PResetxARBI (rst_n),
      .PEnClkxSI   (en),
      .PEnClkxSO   (o_enclk),
      .PSelxSI     (psel),
      .PEnablexSI  (penable),
      .PWritexSI   (pwrite),
      .PAddrxDI    (paddr),
      .PWDataxDI   (pwdata),
      .PReadyxSO   (o_ready),
      .PRDataxDO   (o_rdata),
      .PSlverrxSO  (o_slverr),
      .PSelxSO     (o_sel),
      .PEnablexSO  (o_pen),
      .PWritexSO   (o_pwrite),
      .PAddrxDO    (o_addr),
      .PWDataxDO   (o_wdata),
      .PReadyxSI   (s_rdy),
      .PSlverrxSI  (s_err),
      .PRDataxDI   (s_rdata),
      .TimeoutxSO  (o_tout)
   );

   // counts enabled ACCESS cycles seen by the addressed slave
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_cnt <= 8'd0;
      else if (!((|o_sel) && o_pen)) acc_cnt <= 8'd0;
      else if (en) acc_cnt <= acc_cnt + 8'd1;
   end

   always_comb begin
      s_rdy   = '0;
      s_err   = '0;
      s_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         s_rdy[i] = o_sel[i] & o_pen & ~never_rdy & (acc_cnt >= slv_wait);
         s_err[i] = err_mask[i];
         s_rdata[32*i +: 32] = rd_val[i];
      end
   end

   // one complete master transfer; expected result queued at SETUP, checked at ready
   task automatic do_xfer(input logic [31:0] baddr, input logic wr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_tp,
                          input logic [3:0] exp_sel, input int exp_lat);
      exp_t e, p;
      int lat = 0;
      int tp = 0;
      logic got = 1'b0;
      logic cap = 1'b0;
      logic bad_idle = 1'b0;
      logic [3:0] sel_or = '0;
      logic [3:0] sel_done = '0;
      logic [31:2] c_addr = '0;
      logic [31:0] c_wdata = '0;
      logic c_write = 1'b0;
      e.rdata = exp_rd; e.err = exp_err; e.tpulses = exp_tp; e.sel = exp_sel;
      e.lat = exp_lat; e.addr = baddr[31:2]; e.wdata = wd; e.write = wr;
      @(posedge clk); #1;
      // in toggling mode start so that the next edge is an enabled one
      while (tgl && en_tgl !== 1'b0) begin @(posedge clk); #1; end
      psel = 1'b1; penable = 1'b0; paddr = baddr[31:2]; pwdata = wd; pwrite = wr;
      sb.push_back(e);
      for (int c = 0; c < 100 && !got; c++) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) penable = 1'b1;
         sel_or |= o_sel;
         if (o_tout) tp++;
         if (o_pen && !cap) begin
            cap = 1'b1; c_addr = o_addr; c_wdata = o_wdata; c_write = o_pwrite;
         end
         if (o_ready) begin got = 1'b1; sel_done = o_sel; end
         else if (o_rdata !== 32'h0 || o_slverr !== 1'b0) bad_idle = 1'b1;
      end
      psel = 1'b0; penable = 1'b0;
      p = sb.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL ready_wait addr=%h: no PReadyxSO within 100 cycles", baddr);
      end else begin
         checks += 6;
         if (o_rdata !== p.rdata) begin errors++; $display("FAIL rdata addr=%h: got %h want %h", baddr, o_rdata, p.rdata); end
         if (o_slverr !== p.err) begin errors++; $display("FAIL slverr addr=%h: got %b want %b", baddr, o_slverr, p.err); end
         if (tp != p.tpulses) begin errors++; $display("FAIL timeout_pulse addr=%h: got %0d want %0d", baddr, tp, p.tpulses); end
         if (sel_or !== p.sel || sel_done !== 4'h0) begin errors++; $display("FAIL psel addr=%h: got %b (done %b) want %b", baddr, sel_or, sel_done, p.sel); end
         if (lat != p.lat) begin errors++; $display("FAIL latency addr=%h: got %0d want %0d", baddr, lat, p.lat); end
         if (bad_idle) begin errors++; $display("FAIL resp_outside_done addr=%h: got nonzero want zero", baddr); end
         checks++;
         if (p.sel == 4'h0) begin
            if (cap) begin errors++; $display("FAIL miss_enable addr=%h: got PEnablexSO=1 want 0", baddr); end
         end else if (c_addr !== p.addr || c_wdata !== p.wdata || c_write !== p.write) begin
            errors++;
            $display("FAIL slave_req addr=%h: got %h/%h/%b want %h/%h/%b", baddr,
                     c_addr, c_wdata, c_write, p.addr, p.wdata, p.write);
         end
      end
      // let DONE drain back to IDLE
      for (int c = 0; c < 10 && o_ready; c++) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checks += 2;
      if ({o_ready, o_slverr, o_pen, o_pwrite, o_tout, o_sel, o_rdata, o_addr, o_wdata} !== '0) begin
         errors++; $display("FAIL reset_outputs: got nonzero outputs want all zero");
      end
      if (o_enclk !== 1'b1) begin errors++; $display("FAIL enclk_fwd_1: got %b want 1", o_enclk); end
      en_base = 1'b0; #1;
      checks++;
      if (o_enclk !== 1'b0) begin errors++; $display("FAIL enclk_fwd_0: got %b want 0", o_enclk); end
      en_base = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_read();
      slv_wait = 8'd0;
      do_xfer(32'h0000_0104, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0, 0, 4'b0010, 3);
   endtask

   task automatic test_unmapped_write();
      do_xfer(32'h0000_1000, 1'b1, 32'h1234_5678, 32'h0, 1'b1, 0, 4'b0000, 1);
   endtask

   task automatic test_write_err();
      slv_wait = 8'd2; err_mask = 4'b1000;
      do_xfer(32'h0000_030C, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b1, 0, 4'b1000, 5);
      err_mask = 4'h0;
   endtask

   task automatic test_timeout();
      never_rdy = 1'b1;
      do_xfer(32'h0000_0208, 1'b0, 32'h0, 32'h0, 1'b1, 1, 4'b0100, 17);
      never_rdy = 1'b0;
   endtask

   task automatic test_ready_at_limit();
      slv_wait = 8'd14;
      do_xfer(32'h0000_0210, 1'b0, 32'h0, 32'hA5A5_0002, 1'b0, 0, 4'b0100, 17);
      slv_wait = 8'd0;
   endtask

   task automatic test_clk_enable();
      @(posedge clk); #1 tgl = 1'b1;
      do_xfer(32'h0000_0004, 1'b0, 32'h0, 32'hA5A5_0000, 1'b0, 0, 4'b0001, 5);
      @(posedge clk); #1 tgl = 1'b0;
   endtask

   task automatic test_back_to_back();
      slv_wait = 8'd1;
      rd_val[3] = 32'h3C3C_0F0F;
      do_xfer(32'h0000_0000, 1'b0, 32'h0, 32'hA5A5_0000, 1'b0, 0, 4'b0001, 4);
      do_xfer(32'h0000_03FC, 1'b0, 32'h0, 32'h3C3C_0F0F, 1'b0, 0, 4'b1000, 4);
      do_xfer(32'h0000_0100, 1'b1, 32'h5555_AAAA, 32'h0, 1'b0, 0, 4'b0010, 4);
      slv_wait = 8'd0;
   endtask

   task automatic test_reset_mid();
      never_rdy = 1'b1;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; paddr = 30'h0000_0082; pwrite = 1'b0;
      @(posedge clk); #1 penable = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (o_pen !== 1'b1 || o_sel !== 4'b0100) begin
         errors++; $display("FAIL pre_reset_access: got en=%b sel=%b want en=1 sel=0100", o_pen, o_sel);
      end
      rst_n = 1'b0; #1;
      checks++;
      if (o_sel !== 4'h0 || o_pen !== 1'b0 || o_ready !== 1'b0) begin
         errors++; $display("FAIL async_reset: got sel=%b en=%b rdy=%b want 0/0/0", o_sel, o_pen, o_ready);
      end
      psel = 1'b0; penable = 1'b0; never_rdy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      do_xfer(32'h0000_0104, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0, 0, 4'b0010, 3);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) rd_val[i] = 32'hA5A5_0000 | 32'(i);
      test_reset();
      test_read();
      test_unmapped_write();
      test_write_err();
      test_timeout();
      test_ready_at_limit();
      test_clk_enable();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
